// File: rtl/slice_pkg.sv
// Shared types and constants for the frame slicer: FSM state encoding and legal code rates.
package slice_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } slice_state_t;

    localparam int CODE_RATE_2 = 2;
    localparam int CODE_RATE_3 = 3;

endpackage

// File: rtl/slice_extract.sv
// Combinational codeword extractor: picks up to SYM_PER_CYCLE R-bit codewords MSB-first below rem.
// Latency 0; no flow control of its own, the caller decides when the result is registered.
module slice_extract #(
    parameter int FRAME_W       = 276,
    parameter int MAX_RATE      = 3,
    parameter int SYM_PER_CYCLE = 2,
    parameter int RATE_W        = 2,
    parameter int LEN_W         = $clog2(FRAME_W + 1),
    parameter int OUT_W         = SYM_PER_CYCLE * MAX_RATE
) (
    input  logic [FRAME_W-1:0]       frame_i,
    input  logic [LEN_W-1:0]         rem_i,
    input  logic [RATE_W-1:0]        rate_i,
    output logic [OUT_W-1:0]         rx_o,
    output logic [SYM_PER_CYCLE-1:0] mask_o,
    output logic [LEN_W-1:0]         used_o
);

    logic [LEN_W-1:0] idx;

    always_comb begin
        rx_o   = '0;
        mask_o = '0;
        used_o = '0;
        idx    = '0;
        for (int j = 0; j < SYM_PER_CYCLE; j++) begin
            // Codeword j exists only if all its R bits lie below rem, so the mask stays contiguous.
            if (int'(rem_i) >= (j + 1) * int'(rate_i)) begin
                mask_o[j] = 1'b1;
                used_o    = LEN_W'((j + 1) * int'(rate_i));
                for (int b = 0; b < MAX_RATE; b++) begin
                    if (b < int'(rate_i)) begin
                        idx = rem_i - LEN_W'(j * int'(rate_i)) - LEN_W'(b) - LEN_W'(1);
                        rx_o[j*MAX_RATE+b] = frame_i[idx];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/slice_stream.sv
// Frame slicer: loads a frame via valid/ready, then streams SYM_PER_CYCLE codewords per enabled cycle.
// Latency 1 from enabling edge; en_s low stalls with rem held, i_flush aborts to IDLE.
module slice_stream
    import slice_pkg::*;
#(
    parameter int FRAME_W       = 276,
    parameter int MAX_RATE      = 3,
    parameter int SYM_PER_CYCLE = 2,
    parameter int RATE_W        = 2,
    parameter int LEN_W         = $clog2(FRAME_W + 1),
    parameter int OUT_W         = SYM_PER_CYCLE * MAX_RATE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_frame_valid,
    output logic                     o_frame_ready,
    input  logic [FRAME_W-1:0]       i_data_frame,
    input  logic [LEN_W-1:0]         i_frame_len,
    input  logic [RATE_W-1:0]        i_code_rate,
    input  logic                     en_s,
    input  logic                     i_flush,
    output logic [OUT_W-1:0]         o_rx,
    output logic [SYM_PER_CYCLE-1:0] o_sym_valid,
    output logic                     o_valid,
    output logic                     o_ood,
    output logic                     o_err
);

    slice_state_t             state_q, state_d;
    logic [FRAME_W-1:0]       frame_q, frame_d;
    logic [RATE_W-1:0]        rate_q, rate_d;
    logic [LEN_W-1:0]         rem_q, rem_d;
    logic [OUT_W-1:0]         rx_q, rx_d;
    logic [SYM_PER_CYCLE-1:0] sym_q, sym_d;
    logic                     valid_q, valid_d;
    logic                     ood_q, ood_d;
    logic                     err_q, err_d;

    logic [OUT_W-1:0]         ext_rx;
    logic [SYM_PER_CYCLE-1:0] ext_mask;
    logic [LEN_W-1:0]         used;
    logic [LEN_W-1:0]         rem_next;
    logic [LEN_W-1:0]         len_clamped;
    logic                     len_over;
    logic                     rate_bad;

    slice_extract #(
        .FRAME_W      (FRAME_W),
        .MAX_RATE     (MAX_RATE),
        .SYM_PER_CYCLE(SYM_PER_CYCLE),
        .RATE_W       (RATE_W),
        .LEN_W        (LEN_W),
        .OUT_W        (OUT_W)
    ) u_extract (
        .frame_i(frame_q),
        .rem_i  (rem_q),
        .rate_i (rate_q),
        .rx_o   (ext_rx),
        .mask_o (ext_mask),
        .used_o (used)
    );

    assign o_frame_ready = (state_q == IDLE) && !rst;
    assign len_over      = int'(i_frame_len) > FRAME_W;
    assign len_clamped   = len_over ? LEN_W'(FRAME_W) : i_frame_len;
    assign rate_bad      = (int'(i_code_rate) < CODE_RATE_2) || (int'(i_code_rate) > MAX_RATE);
    assign rem_next      = rem_q - used;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        rate_d  = rate_q;
        rem_d   = rem_q;
        err_d   = err_q;
        rx_d    = '0;
        sym_d   = '0;
        valid_d = 1'b0;
        ood_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_frame_valid && o_frame_ready) begin
                    frame_d = i_data_frame;
                    rate_d  = i_code_rate;
                    rem_d   = len_clamped;
                    err_d   = len_over;
                    if (rate_bad || (len_clamped == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (i_flush) begin
                    state_d = IDLE;
                end else if (en_s) begin
                    valid_d = 1'b1;
                    rx_d    = ext_rx;
                    sym_d   = ext_mask;
                    rem_d   = rem_next;
                    // Fewer than R bits left: this is the final slice; any residue is dropped.
                    if (rem_next < LEN_W'(rate_q)) begin
                        ood_d   = 1'b1;
                        state_d = IDLE;
                        if (rem_next != '0) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            frame_q <= '0;
            rate_q  <= '0;
            rem_q   <= '0;
            rx_q    <= '0;
            sym_q   <= '0;
            valid_q <= 1'b0;
            ood_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            rate_q  <= rate_d;
            rem_q   <= rem_d;
            rx_q    <= rx_d;
            sym_q   <= sym_d;
            valid_q <= valid_d;
            ood_q   <= ood_d;
            err_q   <= err_d;
        end
    end

    assign o_rx        = rx_q;
    assign o_sym_valid = sym_q;
    assign o_valid     = valid_q;
    assign o_ood       = ood_q;
    assign o_err       = err_q;

endmodule
